// File: rtl/spi_slave_regs.sv
// spi_slave_regs: mode-3 SPI responder with an ADXL362-style byte register file.
// Commands: write (CMD_WRITE) and read (CMD_READ), each followed by a start
// address and then data bytes with address auto-increment. Addresses 0-3 are
// read-only ID registers. The host port loads sensor data from the fabric.
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN releases MISO to 'z' when
// this slave is not shifting read data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | CS high, or waiting for a fresh CS falling edge
// S_CMD    | receiving the command byte
// S_ADDR   | receiving the start address byte
// S_DATA   | data bytes; write commits or read shifts out regs[ptr]
// S_IGNORE | unknown command; discard everything until CS rises

module spi_slave_regs #(
    parameter int         DEPTH       = 64,
    parameter logic [7:0] CMD_WRITE   = 8'h0A,
    parameter logic [7:0] CMD_READ    = 8'h0B,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_clk,
    input  logic          CS,
    input  logic          MOSI,
    output logic          MISO,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic          reg_wr_strobe,
    output logic [AW-1:0] reg_wr_addr,
    output logic [7:0]    reg_wr_data,
    output logic          cmd_err,
    output logic          busy
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_e;

    localparam logic [AW-1:0] ID_LAST  = AW'(3);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES:0]   cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      rx_sh_q;
    logic [7:0]      tx_sh_q;
    logic            rd_q;
    logic            miso_q;
    logic [AW-1:0]   ptr_q;
    logic            strobe_q;
    logic [AW-1:0]   wr_addr_q;
    logic [7:0]      wr_data_q;
    logic            cmd_err_q;
    logic [7:0]      regs_q [DEPTH];

    logic            sclk_s, sclk_d, cs_s, cs_d, mosi_s;
    logic            sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic            in_frame, shift_en, byte_done, cmd_ok;
    logic            spi_commit, rd_load, rd_shift, miso_drive;
    logic [7:0]      rx_byte;
    logic [AW-1:0]   ptr_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sclk_d    = sclk_sync_q[SYNC_STAGES];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign cs_d      = cs_sync_q[SYNC_STAGES];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign in_frame   = !cs_s && (state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA);
    assign shift_en   = in_frame && sclk_rise;
    assign byte_done  = shift_en && (bit_cnt_q == 3'd7);
    assign rx_byte    = {rx_sh_q[6:0], mosi_s};
    assign cmd_ok     = (rx_byte == CMD_WRITE) || (rx_byte == CMD_READ);
    assign spi_commit = byte_done && (state_q == S_DATA) && !rd_q;
    assign rd_load    = !cs_s && (state_q == S_DATA) && rd_q && sclk_fall && (bit_cnt_q == 3'd0);
    assign rd_shift   = !cs_s && (state_q == S_DATA) && rd_q && sclk_fall && (bit_cnt_q != 3'd0);
    assign ptr_next   = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);

    // Input synchronizers. The CS chain resets to "selected" so a CS that is
    // already low at reset release never looks like a falling edge; a real
    // start needs CS to be seen high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; CS rising aborts from any state.
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && cs_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cs_fall)   state_d = S_CMD;
                S_CMD:   if (byte_done) state_d = cmd_ok ? S_ADDR : S_IGNORE;
                S_ADDR:  if (byte_done) state_d = S_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from state; MISO only carries data during a read byte.
    always_comb begin
        busy       = (state_q != S_IDLE);
        miso_drive = (state_q == S_DATA) && rd_q && !cs_s;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        MISO = miso_drive ? miso_q : 1'bz;
`else
        MISO = miso_drive ? miso_q : 1'b0;
`endif
    end

    // Shift/count datapath, pointer, strobes and the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= '0;
            rd_q      <= 1'b0;
            miso_q    <= 1'b0;
            ptr_q     <= '0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cmd_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
            regs_q[0] <= 8'hAD;
            regs_q[1] <= 8'h1D;
            regs_q[2] <= 8'hF2;
            regs_q[3] <= 8'h01;
        end else begin
            strobe_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            if (state_q == S_IDLE) begin
                bit_cnt_q <= '0;
                rx_sh_q   <= '0;
                miso_q    <= 1'b0;
            end
            if (shift_en) begin
                rx_sh_q   <= rx_byte;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                case (state_q)
                    S_CMD: begin
                        if (cmd_ok) rd_q <= (rx_byte == CMD_READ);
                        else        cmd_err_q <= 1'b1;
                    end
                    S_ADDR: ptr_q <= rx_byte[AW-1:0];
                    S_DATA: begin
                        if (!rd_q) begin
                            strobe_q  <= 1'b1;
                            wr_addr_q <= ptr_q;
                            wr_data_q <= rx_byte;
                            ptr_q     <= ptr_next;
                        end
                    end
                    default: ;
                endcase
            end
            if (rd_load) begin
                miso_q  <= regs_q[ptr_q][7];
                tx_sh_q <= {regs_q[ptr_q][6:0], 1'b0};
                ptr_q   <= ptr_next;
            end else if (rd_shift) begin
                miso_q  <= tx_sh_q[7];
                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
            end
            // Host load loses to an SPI commit on the same address.
            if (host_we && host_addr > ID_LAST && !(spi_commit && ptr_q == host_addr))
                regs_q[host_addr] <= host_wdata;
            if (spi_commit && ptr_q > ID_LAST)
                regs_q[ptr_q] <= rx_byte;
        end
    end

    assign reg_wr_strobe = strobe_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q;
    assign cmd_err       = cmd_err_q;

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI responder (slave) modelling an ADXL362-style accelerometer register interface, for closed-loop simulation and FPGA self-test of the SPI master.
- Mode 3 only: spi_clk idles high; MOSI is sampled on the rising spi_clk edge; MISO is launched on the falling edge.
- Holds a byte-wide register file with read-only ID registers. Supports write (0x0A) and read (0x0B) commands with address auto-increment.
- Fabric side has a host load port for sensor data and a strobe reporting each SPI register write.

Parameters:
- DEPTH, 64, number of 8-bit registers; address width AW = clog2(DEPTH).
- CMD_WRITE, 8'h0A, write-register command byte.
- CMD_READ, 8'h0B, read-register command byte.
- SYNC_STAGES, 2, synchronizer flops on spi_clk, CS and MOSI (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the spi_clk frequency.
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock from master.
- CS  in  1  chip select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- host_we  in  1  host write enable for the register file.
- host_addr  in  AW  host write address.
- host_wdata  in  8  host write data.
- reg_wr_strobe  out  1  one-clk pulse when an SPI write commits a byte.
- reg_wr_addr  out  AW  address of the committed byte.
- reg_wr_data  out  8  committed byte.
- cmd_err  out  1  one-clk pulse when an unknown command byte is received.
- busy  out  1  high while a transaction is in progress (synchronized CS low).

Behaviour:
- Reset values: MISO=0, reg_wr_strobe=0, reg_wr_addr=0, reg_wr_data=0, cmd_err=0, busy=0, state=IDLE, bit counter=0.
- Register file reset: addresses 0x00-0x03 hold 0xAD, 0x1D, 0xF2, 0x01 (read-only ID); all other addresses = 0x00.
- Input sync: spi_clk, CS and MOSI each pass through SYNC_STAGES flops. Edges are detected against one further delayed copy, so internal latency = SYNC_STAGES+1 clk.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE -> CMD: on synchronized CS falling. Clear bit counter and shift register.
- Rising spi_clk edge (CS low): shift the sampled MOSI in, MSB first, and increment the 3-bit counter. When the counter wraps 7->0, a byte is complete.
- CMD byte complete:
  - 0x0A or 0x0B -> ADDR; latch the read/write flag.
  - any other value -> IGNORE and pulse cmd_err.
- ADDR byte complete: latch the low AW bits as the pointer; -> DATA.
- DATA, write: each completed byte is written to regs[ptr] unless ptr<4.
  - reg_wr_strobe pulses on the clk after completion, with reg_wr_addr/reg_wr_data. It pulses even for ID addresses, but those registers are not modified.
  - Pointer increments after each byte.
- DATA, read: on the first falling spi_clk edge of each data byte (counter==0), load the tx shift register from regs[ptr] and drive bit 7 on MISO.
  - The remaining bits shift out on subsequent falling edges.
  - Pointer increments when the byte load occurs.
- Pointer wraps DEPTH-1 -> 0.
- MISO = 0 in CMD, ADDR and IGNORE states, and while CS is high.
- IGNORE: all activity is discarded until CS rises.
- Synchronized CS rising in any state: -> IDLE, busy=0. A partial byte (counter != 0) is discarded with no write and no strobe.
- Simultaneous host_we and SPI commit to the same address: the SPI write wins; the host write is dropped.
  - Host writes to addresses 0-3 are ignored.
  - Host writes are otherwise accepted in any state.
  - A host write to regs[ptr] before the read load is visible in that byte.
- rst asserted mid-transaction: immediate return to reset values, including the register file. The slave stays in IDLE until a fresh CS falling edge, so a CS already low at reset release is not treated as a start.

Optional Feature:
- Macro SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: MISO = 1'bz whenever CS is high, or the state is not DATA-read, allowing a shared MISO line across slaves.
- Undefined: MISO is driven 0 in those conditions, as specified above.

Test Plan:
- Read ID: CS low, send 0x0B, 0x00, then clock 1 byte -> MISO returns 0xAD. busy=1 during the transaction and 0 after CS rises.
- Multi-byte read: host writes 0x11@0x08, 0x22@0x09. SPI read at 0x08 for 3 bytes -> MISO returns 0x11, 0x22, 0x00.
- Write and strobe: SPI 0x0A, 0x10, 0x5A, 0xA5 -> two strobes, (0x10, 0x5A) then (0x11, 0xA5). A following read at 0x10 returns 0x5A, 0xA5.
- Protection and wrap: SPI write 0x0A, 0x3F, 0x77, 0x88 -> regs[0x3F]=0x77; the write to 0x00 is ignored and 0x00 still reads 0xAD. Two strobes are seen.
- Error and abort:
  - Command 0x55 -> cmd_err is a single-clk pulse, MISO stays 0, no strobe.
  - Separately, write 0x0A, 0x20, then 4 bits, then CS high -> no strobe and regs[0x20] is unchanged.
- Reset mid-read: assert rst for 1 clk during the data byte -> MISO=0, busy=0. regs restored to reset values and regs[0x08]=0x00.
